// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and FSM encoding for the pipeline hold/flush controller.
package pipe_ctrl_pkg;

  localparam logic [63:0] PIPE_RESET_PC  = 64'h8000_0000;
  localparam int          PIPE_STAGES    = 4;
  localparam int          PIPE_DEC_STAGE = 1;
  localparam int          PIPE_MEM_STAGE = 2;

  typedef enum logic [1:0] {
    PIPE_ST_BOOT    = 2'd0,
    PIPE_ST_RUN     = 2'd1,
    PIPE_ST_WAIT_IF = 2'd2
  } pipe_st_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Core <-> pipe_ctrl bundle: stall/hazard/redirect requests in, per-stage controls out.
interface pipe_ctrl_if #(
  parameter int STAGES = 4,
  parameter int ADDR_W = 64
);
  logic              stall_if_i;
  logic              stall_mem_i;
  logic              load_use_i;
  logic              jmp_req_i;
  logic [ADDR_W-1:0] jmp_to_i;
  logic              irq_req_i;
  logic [ADDR_W-1:0] irq_to_i;
  logic [STAGES-1:0] stage_en_o;
  logic [STAGES-1:0] stage_flush_o;
  logic [STAGES-1:0] stage_valid_o;
  logic              redirect_en_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              irq_ack_o;

  // master = core pipeline side, slave = controller side
  modport master (
    output stall_if_i, stall_mem_i, load_use_i, jmp_req_i, jmp_to_i, irq_req_i, irq_to_i,
    input  stage_en_o, stage_flush_o, stage_valid_o, redirect_en_o, redirect_pc_o, irq_ack_o
  );
  modport slave (
    input  stall_if_i, stall_mem_i, load_use_i, jmp_req_i, jmp_to_i, irq_req_i, irq_to_i,
    output stage_en_o, stage_flush_o, stage_valid_o, redirect_en_o, redirect_pc_o, irq_ack_o
  );
endinterface

// File: rtl/pipe_ctrl_redirect_buf.sv
// PC redirect sequencer: boot redirect, same-cycle redirects, and a pending target
// buffered across an outstanding fetch.
module pipe_ctrl_redirect_buf
  import pipe_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PIPE_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall_if,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_req_pc,
  output logic              o_redir_en,
  output logic [ADDR_W-1:0] o_redir_pc,
  output logic              o_wait_exit,
  output pipe_st_e          o_state
);

  pipe_st_e          r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pend_pc, w_pend_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PIPE_ST_BOOT;
      r_pend_pc <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_pc;
    o_redir_en  = 1'b0;
    o_redir_pc  = r_pend_pc;
    o_wait_exit = 1'b0;
    if (rst) begin
      o_redir_pc = RESET_PC;
    end else begin
      case (r_state)
        PIPE_ST_BOOT: begin
          o_redir_en  = 1'b1;
          w_state_nxt = PIPE_ST_RUN;
        end
        PIPE_ST_RUN: begin
          if (i_req) begin
            if (i_stall_if) begin
              w_pend_nxt  = i_req_pc;
              w_state_nxt = PIPE_ST_WAIT_IF;
            end else begin
              o_redir_en = 1'b1;
              o_redir_pc = i_req_pc;
            end
          end
        end
        PIPE_ST_WAIT_IF: begin
          // a trap landing here replaces the buffered target
          if (i_req) w_pend_nxt = i_req_pc;
          if (!i_stall_if) begin
            o_redir_en  = 1'b1;
            o_redir_pc  = w_pend_nxt;
            o_wait_exit = 1'b1;
            w_state_nxt = PIPE_ST_RUN;
          end
        end
        default: w_state_nxt = PIPE_ST_BOOT;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/pipe_ctrl.sv
// Per-stage advance/flush/valid controller for the in-order core; hold point and
// valid chain generated over STAGES, redirect sequencing in the sub-module.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                STAGES    = PIPE_STAGES,
  parameter int                DEC_STAGE = PIPE_DEC_STAGE,
  parameter int                MEM_STAGE = PIPE_MEM_STAGE,
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(PIPE_RESET_PC)
) (
  input  logic     clk,
  input  logic     rst,
  pipe_ctrl_if.slave bus
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_held, w_en, w_flush, w_valid_nxt;
  logic              w_lu, w_trap_ok, w_jmp_ok, w_req, w_wait_exit;
  logic [ADDR_W-1:0] w_req_pc;
  pipe_st_e          w_state;

  assign w_lu      = bus.load_use_i & r_valid[DEC_STAGE];
  assign w_trap_ok = bus.irq_req_i & ~bus.stall_mem_i & ~rst & (w_state != PIPE_ST_BOOT);
  // jump needs DEC_STAGE free to move (hold point below it) and loses to a trap
  assign w_jmp_ok  = bus.jmp_req_i & r_valid[DEC_STAGE] & ~w_held[DEC_STAGE] & ~rst
                   & (w_state == PIPE_ST_RUN) & ~w_trap_ok;
  assign w_req     = w_trap_ok | w_jmp_ok;
  assign w_req_pc  = w_trap_ok ? bus.irq_to_i : bus.jmp_to_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit BELOW_MEM_H = (k <= MEM_STAGE);
    localparam bit BELOW_DEC_H = (k <= DEC_STAGE);
    localparam bit IS_IF       = (k == 0);
    localparam bit TRAP_FL     = (k < MEM_STAGE);
    localparam bit JMP_FL      = (k < DEC_STAGE);
    localparam bit STALE_FL    = (k == 1);
    logic w_bubble, w_prev;

    // masks nest (MEM > DEC > 0), so their OR is the mask of the highest hold
    assign w_held[k] = (bus.stall_mem_i & BELOW_MEM_H) | (w_lu & BELOW_DEC_H)
                     | (bus.stall_if_i & IS_IF);
    assign w_en[k]   = ~rst & ~w_held[k];

    if (k == 0) begin : g_first
      assign w_bubble = 1'b0;
      assign w_prev   = 1'b1;
    end else begin : g_rest
      assign w_bubble = w_held[k-1] & ~w_held[k];
      assign w_prev   = r_valid[k-1];
    end

    assign w_flush[k] = rst | w_bubble | (w_trap_ok & TRAP_FL) | (w_jmp_ok & JMP_FL)
                      | (w_wait_exit & STALE_FL);
    assign w_valid_nxt[k] = w_flush[k] ? 1'b0 : (w_en[k] ? w_prev : r_valid[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else     r_valid <= w_valid_nxt;
  end

  pipe_ctrl_redirect_buf #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_redirect_buf (
    .clk        (clk),
    .rst        (rst),
    .i_stall_if (bus.stall_if_i),
    .i_req      (w_req),
    .i_req_pc   (w_req_pc),
    .o_redir_en (bus.redirect_en_o),
    .o_redir_pc (bus.redirect_pc_o),
    .o_wait_exit(w_wait_exit),
    .o_state    (w_state)
  );

  assign bus.stage_en_o    = w_en;
  assign bus.stage_flush_o = w_flush;
  assign bus.stage_valid_o = r_valid;
  assign bus.irq_ack_o     = w_trap_ok;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: STAGES=4, DEC_STAGE=1, MEM_STAGE=2.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_if #(.STAGES(4), .ADDR_W(64)) bus ();

  pipe_ctrl #(
    .STAGES(4), .DEC_STAGE(1), .MEM_STAGE(2), .ADDR_W(64), .RESET_PC(64'h8000_0000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chkv(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs change #1 after the edge, outputs sampled at negedge
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input logic sif, input logic smem, input logic lu,
                     input logic jr, input logic [63:0] jt,
                     input logic ir, input logic [63:0] it);
    bus.stall_if_i  = sif;
    bus.stall_mem_i = smem;
    bus.load_use_i  = lu;
    bus.jmp_req_i   = jr;
    bus.jmp_to_i    = jt;
    bus.irq_req_i   = ir;
    bus.irq_to_i    = it;
  endtask

  initial begin
    drv(0, 0, 0, 0, 64'h0, 0, 64'h0);
    // reset
    nxt(); nxt(); smp();
    chkv("rst_en", bus.stage_en_o, 4'b0000);
    chkv("rst_flush", bus.stage_flush_o, 4'b1111);
    chkb("rst_redir", bus.redirect_en_o, 1'b0);
    chkp("rst_pc", bus.redirect_pc_o, 64'h8000_0000);
    chkb("rst_ack", bus.irq_ack_o, 1'b0);
    chkv("rst_valid", bus.stage_valid_o, 4'b0000);

    // boot redirect then valid fill
    nxt(); rst = 1'b0; smp();
    chkb("boot_redir", bus.redirect_en_o, 1'b1);
    chkp("boot_pc", bus.redirect_pc_o, 64'h8000_0000);
    chkv("boot_en", bus.stage_en_o, 4'b1111);
    nxt(); smp();
    chkb("run_redir", bus.redirect_en_o, 1'b0);
    chkv("fill1", bus.stage_valid_o, 4'b0001);
    nxt(); smp(); chkv("fill2", bus.stage_valid_o, 4'b0011);
    nxt(); smp(); chkv("fill3", bus.stage_valid_o, 4'b0111);

    // load-use with full pipe
    nxt(); drv(0, 0, 1, 0, 64'h0, 0, 64'h0); smp();
    chkv("fill4", bus.stage_valid_o, 4'b1111);
    chkv("lu_en", bus.stage_en_o, 4'b1100);
    chkv("lu_flush", bus.stage_flush_o, 4'b0100);
    nxt(); drv(0, 0, 0, 0, 64'h0, 0, 64'h0); smp();
    chkv("lu_valid", bus.stage_valid_o, 4'b1011);
    nxt(); smp(); chkv("refill1", bus.stage_valid_o, 4'b0111);

    // three-cycle mem stall, trap raised during it
    nxt(); drv(0, 1, 0, 0, 64'h0, 0, 64'h0); smp();
    chkv("mem1_en", bus.stage_en_o, 4'b1000);
    chkv("mem1_flush", bus.stage_flush_o, 4'b1000);
    nxt(); drv(0, 1, 0, 0, 64'h0, 1, 64'h8000_0040); smp();
    chkv("mem2_en", bus.stage_en_o, 4'b1000);
    chkb("mem2_ack", bus.irq_ack_o, 1'b0);
    chkv("mem2_valid", bus.stage_valid_o, 4'b0111);
    nxt(); smp();
    chkv("mem3_flush", bus.stage_flush_o, 4'b1000);
    chkb("mem3_ack", bus.irq_ack_o, 1'b0);
    nxt(); drv(0, 0, 0, 0, 64'h0, 1, 64'h8000_0040); smp();
    chkb("trap_ack", bus.irq_ack_o, 1'b1);
    chkb("trap_redir", bus.redirect_en_o, 1'b1);
    chkp("trap_pc", bus.redirect_pc_o, 64'h8000_0040);
    chkv("trap_flush", bus.stage_flush_o, 4'b0011);
    nxt(); drv(0, 0, 0, 0, 64'h0, 0, 64'h0); smp();
    chkb("trap_ack_off", bus.irq_ack_o, 1'b0);
    chkv("trap_valid", bus.stage_valid_o, 4'b1100);
    nxt(); smp(); chkv("post_trap1", bus.stage_valid_o, 4'b1001);
    nxt(); smp(); chkv("post_trap2", bus.stage_valid_o, 4'b0011);

    // jump without fetch stall
    nxt(); drv(0, 0, 0, 1, 64'h8000_0100, 0, 64'h0); smp();
    chkv("jmp_pre_valid", bus.stage_valid_o, 4'b0111);
    chkb("jmp_redir", bus.redirect_en_o, 1'b1);
    chkp("jmp_pc", bus.redirect_pc_o, 64'h8000_0100);
    chkv("jmp_flush", bus.stage_flush_o, 4'b0001);
    nxt(); drv(0, 0, 0, 0, 64'h0, 0, 64'h0); smp();
    chkv("jmp_valid", bus.stage_valid_o, 4'b1110);
    chkb("jmp_redir_off", bus.redirect_en_o, 1'b0);
    nxt(); smp(); chkv("post_jmp1", bus.stage_valid_o, 4'b1101);

    // jump during fetch stall, buffered until the fetch returns
    nxt(); drv(1, 0, 0, 1, 64'h8000_0200, 0, 64'h0); smp();
    chkv("jw_pre_valid", bus.stage_valid_o, 4'b1011);
    chkb("jw_redir", bus.redirect_en_o, 1'b0);
    chkv("jw_en", bus.stage_en_o, 4'b1110);
    chkv("jw_flush", bus.stage_flush_o, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      nxt(); drv(1, 0, 0, 0, 64'h0, 0, 64'h0); smp();
      chkb("jw_wait_redir", bus.redirect_en_o, 1'b0);
      chkv("jw_wait_en", bus.stage_en_o, 4'b1110);
    end
    nxt(); drv(0, 0, 0, 0, 64'h0, 0, 64'h0); smp();
    chkb("jw_exit_redir", bus.redirect_en_o, 1'b1);
    chkp("jw_exit_pc", bus.redirect_pc_o, 64'h8000_0200);
    chkv("jw_exit_flush", bus.stage_flush_o, 4'b0010);
    nxt(); smp();
    chkb("jw_run_redir", bus.redirect_en_o, 1'b0);
    chkv("jw_valid", bus.stage_valid_o, 4'b0001);

    // trap and jump together: trap wins
    nxt(); drv(0, 0, 0, 1, 64'h8000_0300, 1, 64'h8000_0004); smp();
    chkv("tj_pre_valid", bus.stage_valid_o, 4'b0011);
    chkb("tj_ack", bus.irq_ack_o, 1'b1);
    chkp("tj_pc", bus.redirect_pc_o, 64'h8000_0004);
    chkv("tj_flush", bus.stage_flush_o, 4'b0011);

    // trap during fetch stall, a second trap overwrites the pending target
    nxt(); drv(1, 0, 0, 0, 64'h0, 1, 64'h8000_0008); smp();
    chkv("tj_valid", bus.stage_valid_o, 4'b0100);
    chkb("tw_ack", bus.irq_ack_o, 1'b1);
    chkb("tw_redir", bus.redirect_en_o, 1'b0);
    chkv("tw_flush", bus.stage_flush_o, 4'b0011);
    nxt(); drv(1, 0, 0, 0, 64'h0, 1, 64'h8000_000C); smp();
    chkb("tw2_ack", bus.irq_ack_o, 1'b1);
    chkb("tw2_redir", bus.redirect_en_o, 1'b0);
    nxt(); drv(0, 0, 0, 0, 64'h0, 0, 64'h0); smp();
    chkb("tw_exit_redir", bus.redirect_en_o, 1'b1);
    chkp("tw_exit_pc", bus.redirect_pc_o, 64'h8000_000C);

    // reset in WAIT_IF drops the pending target
    nxt(); drv(1, 0, 0, 0, 64'h0, 1, 64'h8000_0010); smp();
    chkb("rw_ack", bus.irq_ack_o, 1'b1);
    nxt(); rst = 1'b1; drv(1, 0, 0, 0, 64'h0, 1, 64'h8000_0010); smp();
    chkb("rw_rst_ack", bus.irq_ack_o, 1'b0);
    chkb("rw_rst_redir", bus.redirect_en_o, 1'b0);
    chkv("rw_rst_flush", bus.stage_flush_o, 4'b1111);
    nxt(); rst = 1'b0; drv(0, 0, 0, 0, 64'h0, 0, 64'h0); smp();
    chkb("rw_boot_redir", bus.redirect_en_o, 1'b1);
    chkp("rw_boot_pc", bus.redirect_pc_o, 64'h8000_0000);
    chkv("rw_boot_valid", bus.stage_valid_o, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
